// File: rtl/axi_full_slave_mem.sv
// axi_full_slave_mem: AXI4-full slave backed by a word array.
// Accepts INCR/FIXED write bursts with byte strobes and returns read bursts.
// Unsupported burst types and write bursts with the wrong beat count get SLVERR.
// The write and read channels are independent FSMs that share the array.
//
// Ports:
//   ACLK, ARESETN                     clock, async active-low reset
//   S_AXI_AW* (ADDR, LEN, BURST, VALID/READY)   write address channel
//   S_AXI_W*  (DATA, STRB, LAST, VALID/READY)   write data channel
//   S_AXI_B*  (RESP, VALID/READY)               write response channel
//   S_AXI_AR* (ADDR, LEN, BURST, VALID/READY)   read address channel
//   S_AXI_R*  (DATA, RESP, LAST, VALID/READY)   read data channel
module axi_full_slave_mem #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 10
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                        S_AXI_AWLEN,
  input  logic [1:0]                        S_AXI_AWBURST,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WLAST,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                        S_AXI_ARLEN,
  input  logic [1:0]                        S_AXI_ARBURST,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RLAST,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);

  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned LSB   = $clog2(NB);
  localparam int unsigned IW    = AW - LSB;
  localparam int unsigned DEPTH = 2 ** IW;
  localparam int unsigned CW    = 9;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  // Array contents start at zero and survive ARESETN.
  logic [DW-1:0] r_mem [DEPTH] = '{default: '0};

  // Low address bits select bytes within a word and are ignored.
  logic w_unused;
  assign w_unused = ^{S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

  // ---------------------------------------------------------------- write path
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  w_state_e          r_wstate, w_wstate_nxt;
  logic              r_awready, r_wready, r_bvalid;
  logic [1:0]        r_bresp;
  logic [IW-1:0]     r_widx;
  logic              r_wfixed, r_wbad;
  logic [7:0]        r_wlen;
  logic [CW-1:0]     r_wcnt;
  logic              w_aw_hs, w_w_hs, w_b_hs, w_wr_en;

  assign w_aw_hs = S_AXI_AWVALID & r_awready;
  assign w_w_hs  = S_AXI_WVALID  & r_wready;
  assign w_b_hs  = S_AXI_BREADY  & r_bvalid;
  // Beats past AWLEN+1 and unsupported bursts are accepted but not stored.
  assign w_wr_en = w_w_hs & ~r_wbad & (r_wcnt <= {1'b0, r_wlen});

  // Write FSM next state.
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs)                w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_hs && S_AXI_WLAST) w_wstate_nxt = W_RESP;
      W_RESP:  if (w_b_hs)                 w_wstate_nxt = W_IDLE;
      default:                             w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_wstate <= W_IDLE;
    else          r_wstate <= w_wstate_nxt;
  end

  // Write channel handshakes, burst tracking and response.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_widx    <= '0;
      r_wfixed  <= 1'b0;
      r_wbad    <= 1'b0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
    end else begin
      r_awready <= (w_wstate_nxt == W_IDLE);
      r_wready  <= (w_wstate_nxt == W_DATA);
      r_bvalid  <= (w_wstate_nxt == W_RESP);
      if (w_aw_hs) begin
        r_widx   <= S_AXI_AWADDR[AW-1:LSB];
        r_wfixed <= (S_AXI_AWBURST == BURST_FIXED);
        r_wbad   <= S_AXI_AWBURST[1];
        r_wlen   <= S_AXI_AWLEN;
        r_wcnt   <= '0;
      end
      if (w_w_hs) begin
        if (!r_wfixed)     r_widx <= r_widx + IW'(1);
        // Saturate so a runaway burst can never alias back to a legal count.
        if (r_wcnt != '1)  r_wcnt <= r_wcnt + CW'(1);
        if (S_AXI_WLAST)
          r_bresp <= (r_wbad || (r_wcnt != {1'b0, r_wlen})) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Byte-enabled array write.
  always_ff @(posedge ACLK) begin
    if (w_wr_en) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (S_AXI_WSTRB[b]) r_mem[r_widx][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read path
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  r_state_e          r_rstate, w_rstate_nxt;
  logic              r_arready, r_rvalid, r_rlast;
  logic [DW-1:0]     r_rdata;
  logic [1:0]        r_rresp;
  logic [IW-1:0]     r_ridx;
  logic              r_rfixed, r_rbad;
  logic [7:0]        r_rlen, r_rcnt;
  logic [IW-1:0]     w_ar_idx;
  logic              w_ar_hs, w_r_hs;

  assign w_ar_hs  = S_AXI_ARVALID & r_arready;
  assign w_r_hs   = S_AXI_RREADY  & r_rvalid;
  assign w_ar_idx = S_AXI_ARADDR[AW-1:LSB];

  // Read FSM next state.
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs)           w_rstate_nxt = R_DATA;
      R_DATA:  if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
      default:                        w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_rstate <= R_IDLE;
    else          r_rstate <= w_rstate_nxt;
  end

  // Read beat register: loads beat 0 on AR, next beat on each R handshake.
  // Array reads see pre-edge contents, so a same-cycle write is not visible.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_ridx    <= '0;
      r_rfixed  <= 1'b0;
      r_rbad    <= 1'b0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
    end else begin
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_DATA);
      if (w_ar_hs) begin
        r_rbad   <= S_AXI_ARBURST[1];
        r_rfixed <= (S_AXI_ARBURST == BURST_FIXED);
        r_rlen   <= S_AXI_ARLEN;
        r_rcnt   <= '0;
        r_rdata  <= S_AXI_ARBURST[1] ? '0 : r_mem[w_ar_idx];
        r_rresp  <= S_AXI_ARBURST[1] ? RESP_SLVERR : RESP_OKAY;
        r_rlast  <= (S_AXI_ARLEN == 8'd0);
        r_ridx   <= (S_AXI_ARBURST == BURST_FIXED) ? w_ar_idx : w_ar_idx + IW'(1);
      end else if (w_r_hs) begin
        if (r_rlast) begin
          r_rlast <= 1'b0;
        end else begin
          r_rdata <= r_rbad ? '0 : r_mem[r_ridx];
          if (!r_rfixed) r_ridx <= r_ridx + IW'(1);
          r_rcnt  <= r_rcnt + 8'(1);
          r_rlast <= ((r_rcnt + 8'(1)) == r_rlen);
        end
      end
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RLAST   = r_rlast;

endmodule

// File: tb/tb_axi_full_slave_mem.sv
// Directed-vector bench for axi_full_slave_mem (32-bit data, 10-bit address).
module tb_axi_full_slave_mem;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = '0;
  logic [1:0]    awburst = '0;
  logic          awvalid = 1'b0, awready;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wlast = 1'b0, wvalid = 1'b0, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready = 1'b0;
  logic [AW-1:0] araddr = '0;
  logic [7:0]    arlen = '0;
  logic [1:0]    arburst = '0;
  logic          arvalid = 1'b0, arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready = 1'b0;

  always #5 clk = ~clk;

  axi_full_slave_mem #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW)) u_dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWBURST(awburst),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARBURST(arburst),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] rd_data [$];
  logic [1:0]    rd_resp [$];
  logic          rd_last [$];
  logic [1:0]    resp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full write burst: sends nbeats beats of base+i, WLAST on the last one sent.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input int nbeats, input logic [DW-1:0] base, input logic [3:0] strb,
                           output logic [1:0] rsp);
    bit h;
    int t;
    logic [1:0] r;
    awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    t = 0;
    do begin h = awready; @(posedge clk); #1; t++; end while (!h && t < 50);
    awvalid = 1'b0;
    check("aw_hs", 64'(h), 64'(1));
    check("aw_to_w", 64'({awready, wready}), 64'(2'b01));
    for (int i = 0; i < nbeats; i++) begin
      wdata = base + DW'(i); wstrb = strb; wlast = (i == nbeats - 1); wvalid = 1'b1;
      t = 0;
      do begin h = wready; @(posedge clk); #1; t++; end while (!h && t < 50);
      check("w_hs", 64'(h), 64'(1));
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("w_to_b", 64'({wready, bvalid}), 64'(2'b01));
    bready = 1'b1;
    r = 2'bxx;
    t = 0;
    do begin h = bvalid; r = bresp; @(posedge clk); #1; t++; end while (!h && t < 50);
    bready = 1'b0;
    check("b_hs", 64'(h), 64'(1));
    check("b_to_aw", 64'({awready, bvalid}), 64'(2'b10));
    rsp = r;
  endtask

  task automatic ar_start(input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] burst);
    bit h;
    int t;
    araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    t = 0;
    do begin h = arready; @(posedge clk); #1; t++; end while (!h && t < 50);
    arvalid = 1'b0;
    check("ar_hs", 64'(h), 64'(1));
    check("ar_to_r", 64'({arready, rvalid}), 64'(2'b01));
  endtask

  // Full read burst into rd_* queues; bp enables random RREADY stalls.
  task automatic axi_read(input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input bit bp);
    bit v, rr;
    int t;
    logic [DW-1:0] d;
    logic [1:0] rs;
    logic l;
    rd_data.delete(); rd_resp.delete(); rd_last.delete();
    ar_start(addr, len, burst);
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      do begin
        rr = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        rready = rr; v = rvalid; d = rdata; rs = rresp; l = rlast;
        @(posedge clk); #1; t++;
        if (v && !rr) begin
          check("stall_data", 64'(rdata), 64'(d));
          check("stall_last", 64'(rlast), 64'(l));
        end
      end while (!(v && rr) && t < 50);
      check("r_hs", 64'(v && rr), 64'(1));
      rd_data.push_back(d); rd_resp.push_back(rs); rd_last.push_back(l);
    end
    rready = 1'b0;
    check("r_done", 64'({rvalid, arready}), 64'(2'b01));
  endtask

  // Compare an INCR-valued read burst: beat i expected base+i unless zero_from <= i.
  task automatic check_burst(input string tag, input int nbeats, input logic [DW-1:0] base,
                             input int zero_from, input logic [1:0] exp_resp);
    check({tag, "_len"}, 64'(rd_data.size()), 64'(nbeats));
    for (int i = 0; i < nbeats && i < rd_data.size(); i++) begin
      check({tag, "_data"}, 64'(rd_data[i]), (i >= zero_from) ? 64'(0) : 64'(base + DW'(i)));
      check({tag, "_resp"}, 64'(rd_resp[i]), 64'(exp_resp));
      check({tag, "_last"}, 64'(rd_last[i]), 64'(i == nbeats - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_hs", 64'({awready, wready, bvalid, arready, rvalid, rlast}), 64'(0));
    check("rst_data", 64'({bresp, rresp, rdata}), 64'(0));
    rst_n = 1'b1;
    check("rel_low", 64'({awready, arready}), 64'(0));
    @(posedge clk); #1;
    check("rel_rdy", 64'({awready, arready}), 64'(2'b11));

    // INCR write then readback.
    axi_write(10'h010, 8'd3, INCR, 4, 32'hA0, 4'hF, resp);
    check("incr_bresp", 64'(resp), 64'(0));
    axi_read(10'h010, 8'd3, INCR, 1'b0);
    check_burst("incr_rd", 4, 32'hA0, 99, 2'b00);

    // Byte strobes.
    axi_write(10'h020, 8'd0, INCR, 1, 32'hFFFF_FFFF, 4'hF, resp);
    axi_write(10'h020, 8'd0, INCR, 1, 32'h1234_5678, 4'h5, resp);
    check("strb_bresp", 64'(resp), 64'(0));
    axi_read(10'h020, 8'd0, INCR, 1'b0);
    check("strb_rd", 64'(rd_data[0]), 64'h0000_0000_FF34_FF78);

    // FIXED burst writes one word; neighbour untouched.
    axi_write(10'h040, 8'd3, FIXED, 4, 32'h1, 4'hF, resp);
    check("fixed_bresp", 64'(resp), 64'(0));
    axi_read(10'h040, 8'd0, INCR, 1'b0);
    check("fixed_rd", 64'(rd_data[0]), 64'h4);
    axi_read(10'h044, 8'd0, INCR, 1'b0);
    check("fixed_nb", 64'(rd_data[0]), 64'h0);

    // Unsupported burst type: SLVERR, memory unchanged, read data zero.
    axi_write(10'h010, 8'd0, 2'b10, 1, 32'hDEAD_BEEF, 4'hF, resp);
    check("badw_bresp", 64'(resp), 64'(2'b10));
    axi_read(10'h010, 8'd0, INCR, 1'b0);
    check("badw_mem", 64'(rd_data[0]), 64'hA0);
    axi_read(10'h010, 8'd1, 2'b11, 1'b0);
    check_burst("badr", 2, 32'h0, 0, 2'b10);

    // Early WLAST: SLVERR, first two beats stored.
    axi_write(10'h080, 8'd3, INCR, 2, 32'hB0, 4'hF, resp);
    check("early_bresp", 64'(resp), 64'(2'b10));
    axi_read(10'h080, 8'd3, INCR, 1'b0);
    check_burst("early_rd", 4, 32'hB0, 2, 2'b00);

    // Extra beat past AWLEN: SLVERR, extra beat dropped.
    axi_write(10'h0C0, 8'd0, INCR, 2, 32'h55, 4'hF, resp);
    check("extra_bresp", 64'(resp), 64'(2'b10));
    axi_read(10'h0C0, 8'd1, INCR, 1'b0);
    check_burst("extra_rd", 2, 32'h55, 1, 2'b00);

    // Read wraps from last word to word 0; low address bits ignored.
    axi_write(10'h3FC, 8'd0, INCR, 1, 32'hC0, 4'hF, resp);
    axi_write(10'h000, 8'd0, INCR, 1, 32'hC1, 4'hF, resp);
    axi_read(10'h3FF, 8'd1, INCR, 1'b0);
    check_burst("wrap_rd", 2, 32'hC0, 99, 2'b00);

    // 16-beat read under random back-pressure.
    axi_write(10'h100, 8'd15, INCR, 16, 32'hD00, 4'hF, resp);
    check("long_bresp", 64'(resp), 64'(0));
    axi_read(10'h100, 8'd15, INCR, 1'b1);
    check_burst("bp_rd", 16, 32'hD00, 99, 2'b00);

    // Concurrent write and read bursts.
    fork
      axi_write(10'h200, 8'd3, INCR, 4, 32'hE0, 4'hF, resp);
      axi_read(10'h104, 8'd3, INCR, 1'b1);
    join
    check("conc_bresp", 64'(resp), 64'(0));
    check_burst("conc_rd", 4, 32'hD01, 99, 2'b00);
    axi_read(10'h200, 8'd3, INCR, 1'b0);
    check_burst("conc_wr", 4, 32'hE0, 99, 2'b00);

    // Reset in the middle of a read burst.
    ar_start(10'h100, 8'd7, INCR);
    rready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("mid_beat2", 64'(rdata), 64'hD02);
    rst_n = 1'b0;
    #1;
    check("abort_out", 64'({rvalid, rlast, arready, awready, rdata}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_rel", 64'(arready), 64'(0));
    @(posedge clk); #1;
    check("abort_rdy", 64'({arready, rvalid}), 64'(2'b10));
    axi_read(10'h108, 8'd1, INCR, 1'b0);
    check_burst("after_rst", 2, 32'hD02, 99, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_full_slave_mem.md
# axi_full_slave_mem
AXI4-full slave memory that terminates the full-AXI master's burst traffic in place of the VIP slave, so the master plus memory can be simulated or built without a VIP agent. It holds a word array, accepts INCR/FIXED write bursts with byte strobes, returns read bursts, and flags malformed bursts with SLVERR. The write and read paths are independent state machines sharing one array.
## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; 32 or 64 only; beat size is always full width.
- C_S_AXI_ADDR_WIDTH, 10: byte address width; depth = 2^ADDR_WIDTH / (DATA_WIDTH/8) words.
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  reset, asynchronous assert, active-low, released synchronously by upstream.
- S_AXI_AWADDR  in  ADDR_WIDTH  write burst start byte address.
- S_AXI_AWLEN  in  8  beats minus one.
- S_AXI_AWBURST  in  2  00 FIXED, 01 INCR, 10/11 unsupported.
- S_AXI_AWVALID  in  1  / S_AXI_AWREADY  out  1  write-address handshake.
- S_AXI_WDATA  in  DATA_WIDTH  write beat data.
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables.
- S_AXI_WLAST  in  1  final write beat.
- S_AXI_WVALID  in  1  / S_AXI_WREADY  out  1  write-data handshake.
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR.
- S_AXI_BVALID  out  1  / S_AXI_BREADY  in  1  write-response handshake.
- S_AXI_ARADDR  in  ADDR_WIDTH  read burst start byte address.
- S_AXI_ARLEN  in  8  beats minus one.
- S_AXI_ARBURST  in  2  as AWBURST.
- S_AXI_ARVALID  in  1  / S_AXI_ARREADY  out  1  read-address handshake.
- S_AXI_RDATA  out  DATA_WIDTH  read beat data.
- S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR.
- S_AXI_RLAST  out  1  final read beat.
- S_AXI_RVALID  out  1  / S_AXI_RREADY  in  1  read-data handshake.
- No ID, LOCK, CACHE, PROT, QOS, USER or SIZE signals.
## Operation
- Word index = byte address >> log2(DATA_WIDTH/8), modulo depth. Low address bits are ignored, and addresses past the depth wrap to word 0.
- INCR: the index increments per beat and wraps modulo depth. FIXED: the index is constant.
- Unsupported burst type: full handshake still completes, writes are suppressed, read data is 0, response is SLVERR on every beat or on B.
- Write FSM: W_IDLE (AWREADY=1) -> AW handshake -> W_DATA (WREADY=1).
  - Each W handshake writes the bytes enabled by WSTRB and increments a beat counter.
  - The handshake with WLAST=1 moves the FSM to W_RESP (BVALID=1); B handshake returns it to W_IDLE.
  - If the beat count at WLAST differs from AWLEN+1, BRESP=SLVERR.
  - Beats beyond AWLEN+1 are accepted but not written.
- Read FSM: R_IDLE (ARREADY=1) -> AR handshake -> R_DATA.
  - RDATA is a register loaded from the array; the next beat is loaded on each R handshake.
  - RLAST=1 on beat ARLEN+1. The R handshake with RLAST returns the FSM to R_IDLE.
- One outstanding burst per direction. Reads and writes run concurrently.
- Array contents initialise to 0 at configuration and are not cleared by ARESETN.
## Timing
- Reset: AWREADY, WREADY, BVALID, ARREADY, RVALID and RLAST are 0; BRESP, RRESP and RDATA are 0. FSMs go to IDLE asynchronously.
- AWREADY and ARREADY rise at the first ACLK edge after ARESETN goes high.
- AW handshake at edge n: AWREADY=0 and WREADY=1 from n+1.
- Last W beat at edge m: WREADY=0 and BVALID=1 from m+1. BVALID holds until BREADY.
- B handshake at edge k: AWREADY=1 from k+1, giving a 1-cycle bubble between write bursts.
- AR handshake at edge n: RVALID=1 with beat 0 from n+1.
- Read throughput is one beat per cycle while RREADY=1. With RREADY=0, RDATA, RRESP and RLAST hold stable.
- After the final R handshake at edge k: RVALID=0 and ARREADY=1 from k+1.
- Write and read to the same word in the same cycle: the read register captures old data (read-first).
- ARESETN low mid-burst: the burst aborts immediately and no B or further R beats are issued. Beats already written stay in memory.
## Test plan
- INCR write at 0x010, AWLEN=3, data 0xA0..0xA3, WSTRB=F -> BRESP=00 one cycle after the last beat. INCR read from 0x010, ARLEN=3 -> 0xA0..0xA3, RLAST on beat 4, RRESP=00.
- Write 0xFFFFFFFF to 0x020, then write 0x12345678 with WSTRB=0101 -> readback 0xFF34FF78.
- FIXED write of 4 beats 1,2,3,4 to 0x040 -> single-beat read returns 4. AWBURST=10 write -> BRESP=10 and memory unchanged.
- WLAST on beat 2 with AWLEN=3 -> BRESP=10 and beats 1-2 written. INCR read starting at the last word with ARLEN=1 -> second beat comes from word 0.
- Random RREADY back-pressure during an ARLEN=15 read -> RDATA and RLAST stable while stalled, 16 beats in order. Concurrent write and read bursts -> both complete correctly.
- ARESETN pulsed low on beat 2 of an ARLEN=7 read -> RVALID=0 at once, ARREADY=1 on the first edge after release, and a new read returns correct data.
